// File: rtl/intersection_light_ctrl.sv
// intersection_light_ctrl: two-road light sequencer with per-road saturating
// car queues. Highway rests on green; side road is served on demand.
// Optional macro TRAFFIC_STATS_EN builds the served-car counters.
// Ports:
//   traffic_clk, reset          clock, synchronous active-high reset
//   hw_arrive, side_arrive      one car arrives on that road this cycle
//   hw_light, side_light        lamps: 00 red, 01 yellow, 10 green
//   highWay_Green               high only while highway is green
//   hw_depart, side_depart      one queued car leaves this cycle
//   hw_queue, side_queue        waiting car counts (saturating)
//   hw_served, side_served      cars served (0 without TRAFFIC_STATS_EN)
module intersection_light_ctrl #(
    parameter int GREEN_MIN   = 4,
    parameter int GREEN_MAX   = 12,
    parameter int YELLOW_TIME = 2,
    parameter int QUEUE_W     = 5
) (
    input  logic               traffic_clk,
    input  logic               reset,
    input  logic               hw_arrive,
    input  logic               side_arrive,
    output logic [1:0]         hw_light,
    output logic [1:0]         side_light,
    output logic               highWay_Green,
    output logic               hw_depart,
    output logic               side_depart,
    output logic [QUEUE_W-1:0] hw_queue,
    output logic [QUEUE_W-1:0] side_queue,
    output logic [15:0]        hw_served,
    output logic [15:0]        side_served
);

    localparam int CNT_W = (GREEN_MAX > 1) ? $clog2(GREEN_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] MIN_M1  = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_TIME - 1);

    localparam logic [QUEUE_W-1:0] Q_MAX = '1;

    localparam logic [1:0] LAMP_RED = 2'b00;
    localparam logic [1:0] LAMP_YEL = 2'b01;
    localparam logic [1:0] LAMP_GRN = 2'b10;

    typedef enum logic [2:0] {
        HW_GREEN,
        HW_YELLOW,
        RED_TO_SIDE,
        SIDE_GREEN,
        SIDE_YELLOW,
        RED_TO_HW
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_state_cnt;
    logic [CNT_W-1:0]   w_next_cnt;
    logic [QUEUE_W-1:0] r_hw_queue;
    logic [QUEUE_W-1:0] r_side_queue;
    logic [QUEUE_W-1:0] w_hw_queue_next;
    logic [QUEUE_W-1:0] w_side_queue_next;

    logic w_min_done;
    logic w_cnt_max;
    logic w_yel_done;
    logic w_hw_wait;
    logic w_side_wait;
    logic w_hw_depart;
    logic w_side_depart;

    // Decisions look only at registered queues, never at this cycle's arrival.
    assign w_min_done  = (r_state_cnt >= MIN_M1);
    assign w_cnt_max   = (r_state_cnt == CNT_MAX);
    assign w_yel_done  = (r_state_cnt == YEL_M1);
    assign w_hw_wait   = (r_hw_queue != '0);
    assign w_side_wait = (r_side_queue != '0);

    assign w_hw_depart   = (r_state == HW_GREEN) && w_hw_wait;
    assign w_side_depart = (r_state == SIDE_GREEN) && w_side_wait;

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            HW_GREEN: begin
                if (w_min_done && w_side_wait && (!w_hw_wait || w_cnt_max))
                    w_next_state = HW_YELLOW;
            end
            HW_YELLOW: begin
                if (w_yel_done)
                    w_next_state = RED_TO_SIDE;
            end
            RED_TO_SIDE: w_next_state = SIDE_GREEN;
            SIDE_GREEN: begin
                if (w_min_done && (!w_side_wait || (w_hw_wait && w_cnt_max)))
                    w_next_state = SIDE_YELLOW;
            end
            SIDE_YELLOW: begin
                if (w_yel_done)
                    w_next_state = RED_TO_HW;
            end
            RED_TO_HW: w_next_state = HW_GREEN;
            default:   w_next_state = HW_GREEN;
        endcase
    end

    // Counter restarts on every state entry and parks at GREEN_MAX-1.
    always_comb begin
        w_next_cnt = r_state_cnt;
        if (w_next_state != r_state)
            w_next_cnt = '0;
        else if (!w_cnt_max)
            w_next_cnt = r_state_cnt + 1'b1;
    end

    // Arrive+depart cancel; a lone arrival at full scale is dropped.
    always_comb begin
        w_hw_queue_next = r_hw_queue;
        if (hw_arrive && !w_hw_depart && (r_hw_queue != Q_MAX))
            w_hw_queue_next = r_hw_queue + 1'b1;
        else if (!hw_arrive && w_hw_depart)
            w_hw_queue_next = r_hw_queue - 1'b1;
    end

    always_comb begin
        w_side_queue_next = r_side_queue;
        if (side_arrive && !w_side_depart && (r_side_queue != Q_MAX))
            w_side_queue_next = r_side_queue + 1'b1;
        else if (!side_arrive && w_side_depart)
            w_side_queue_next = r_side_queue - 1'b1;
    end

    always_ff @(posedge traffic_clk) begin
        if (reset) begin
            r_state      <= HW_GREEN;
            r_state_cnt  <= '0;
            r_hw_queue   <= '0;
            r_side_queue <= '0;
        end else begin
            r_state      <= w_next_state;
            r_state_cnt  <= w_next_cnt;
            r_hw_queue   <= w_hw_queue_next;
            r_side_queue <= w_side_queue_next;
        end
    end

    // Moore lamp decode from the state register.
    always_comb begin
        hw_light      = LAMP_RED;
        side_light    = LAMP_RED;
        highWay_Green = 1'b0;
        unique case (r_state)
            HW_GREEN: begin
                hw_light      = LAMP_GRN;
                highWay_Green = 1'b1;
            end
            HW_YELLOW:   hw_light   = LAMP_YEL;
            SIDE_GREEN:  side_light = LAMP_GRN;
            SIDE_YELLOW: side_light = LAMP_YEL;
            RED_TO_SIDE,
            RED_TO_HW: begin
                hw_light   = LAMP_RED;
                side_light = LAMP_RED;
            end
            default: begin
                hw_light   = LAMP_RED;
                side_light = LAMP_RED;
            end
        endcase
    end

    assign hw_depart   = w_hw_depart;
    assign side_depart = w_side_depart;
    assign hw_queue    = r_hw_queue;
    assign side_queue  = r_side_queue;

`ifdef TRAFFIC_STATS_EN
    logic [15:0] r_hw_served;
    logic [15:0] r_side_served;

    always_ff @(posedge traffic_clk) begin
        if (reset) begin
            r_hw_served   <= '0;
            r_side_served <= '0;
        end else begin
            if (w_hw_depart && (r_hw_served != 16'hFFFF))
                r_hw_served <= r_hw_served + 16'd1;
            if (w_side_depart && (r_side_served != 16'hFFFF))
                r_side_served <= r_side_served + 16'd1;
        end
    end

    assign hw_served   = r_hw_served;
    assign side_served = r_side_served;
`else
    assign hw_served   = 16'd0;
    assign side_served = 16'd0;
`endif

endmodule

// File: tb/tb_intersection_light_ctrl.sv
// tb_intersection_light_ctrl: directed stimulus pushes per-cycle expected
// outputs into a scoreboard; a negedge monitor pops and compares them.
module tb_intersection_light_ctrl;

    localparam int S_HG = 0;
    localparam int S_HY = 1;
    localparam int S_RS = 2;
    localparam int S_SG = 3;
    localparam int S_SY = 4;
    localparam int S_RH = 5;

    logic        traffic_clk;
    logic        reset;
    logic        hw_arrive;
    logic        side_arrive;
    logic [1:0]  hw_light;
    logic [1:0]  side_light;
    logic        highWay_Green;
    logic        hw_depart;
    logic        side_depart;
    logic [4:0]  hw_queue;
    logic [4:0]  side_queue;
    logic [15:0] hw_served;
    logic [15:0] side_served;

    intersection_light_ctrl #(
        .GREEN_MIN  (4),
        .GREEN_MAX  (12),
        .YELLOW_TIME(2),
        .QUEUE_W    (5)
    ) dut (
        .traffic_clk  (traffic_clk),
        .reset        (reset),
        .hw_arrive    (hw_arrive),
        .side_arrive  (side_arrive),
        .hw_light     (hw_light),
        .side_light   (side_light),
        .highWay_Green(highWay_Green),
        .hw_depart    (hw_depart),
        .side_depart  (side_depart),
        .hw_queue     (hw_queue),
        .side_queue   (side_queue),
        .hw_served    (hw_served),
        .side_served  (side_served)
    );

    initial traffic_clk = 1'b0;
    always #5 traffic_clk = ~traffic_clk;

    typedef struct {
        string       tag;
        logic [1:0]  hl;
        logic [1:0]  sl;
        logic        hg;
        logic        hd;
        logic        sd;
        logic [4:0]  hq;
        logic [4:0]  sq;
        logic [15:0] hs;
        logic [15:0] ss;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    int n_cmp = 0;
    int n_bad = 0;
    int e_hs  = 0;
    int e_ss  = 0;

    task automatic chk(input string tag, input string fld,
                       input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s @%0t: got %0h expected %0h",
                     tag, fld, $time, act, exp);
        end
    endtask

    always @(negedge traffic_clk) begin
        if (sb.size() != 0) begin
            m_e = sb.pop_front();
            chk(m_e.tag, "hw_light", 16'(hw_light), 16'(m_e.hl));
            chk(m_e.tag, "side_light", 16'(side_light), 16'(m_e.sl));
            chk(m_e.tag, "hwGreen", 16'(highWay_Green), 16'(m_e.hg));
            chk(m_e.tag, "hw_depart", 16'(hw_depart), 16'(m_e.hd));
            chk(m_e.tag, "side_depart", 16'(side_depart), 16'(m_e.sd));
            chk(m_e.tag, "hw_queue", 16'(hw_queue), 16'(m_e.hq));
            chk(m_e.tag, "side_queue", 16'(side_queue), 16'(m_e.sq));
            chk(m_e.tag, "hw_served", hw_served, m_e.hs);
            chk(m_e.tag, "side_served", side_served, m_e.ss);
        end
    end

    // Drive this cycle's inputs and queue the outputs expected in this cycle.
    task automatic step(input string tag, input logic rst,
                        input logic ha, input logic sa,
                        input int st, input int hq, input int sq);
        exp_t e;
        reset       = rst;
        hw_arrive   = ha;
        side_arrive = sa;
        e.tag = tag;
        e.hl  = (st == S_HG) ? 2'b10 : (st == S_HY) ? 2'b01 : 2'b00;
        e.sl  = (st == S_SG) ? 2'b10 : (st == S_SY) ? 2'b01 : 2'b00;
        e.hg  = (st == S_HG);
        e.hd  = (st == S_HG) && (hq != 0);
        e.sd  = (st == S_SG) && (sq != 0);
        e.hq  = 5'(hq);
        e.sq  = 5'(sq);
        e.hs  = 16'(e_hs);
        e.ss  = 16'(e_ss);
        sb.push_back(e);
`ifdef TRAFFIC_STATS_EN
        if (rst) begin
            e_hs = 0;
            e_ss = 0;
        end else begin
            if (e.hd) e_hs++;
            if (e.sd) e_ss++;
        end
`endif
        @(posedge traffic_clk);
        #1;
    endtask

    // Hand-derived timeline for both roads saturated with arrivals from
    // HW_GREEN entry: k is cycles since that entry.
    function automatic int st4(input int k);
        if (k < 12) return S_HG;
        if (k < 14) return S_HY;
        if (k < 15) return S_RS;
        if (k < 27) return S_SG;
        if (k < 29) return S_SY;
        if (k < 30) return S_RH;
        if (k < 42) return S_HG;
        if (k < 44) return S_HY;
        if (k < 45) return S_RS;
        if (k < 57) return S_SG;
        return S_SY;
    endfunction

    function automatic int hq4(input int k);
        if (k == 0) return 0;
        if (k < 13) return 1;
        if (k < 30) return k - 11;
        if (k < 43) return 19;
        if (k < 55) return k - 23;
        return 31;
    endfunction

    function automatic int sq4(input int k);
        if (k < 16) return k;
        if (k < 28) return 15;
        if (k < 43) return k - 12;
        return 31;
    endfunction

    initial begin
        reset       = 1'b1;
        hw_arrive   = 1'b0;
        side_arrive = 1'b0;
        @(posedge traffic_clk);
        #1;

        for (int i = 0; i < 4; i++) step("rst", 1, 1, 1, S_HG, 0, 0);
        for (int i = 0; i < 20; i++) step("idle", 0, 0, 0, S_HG, 0, 0);

        step("rst2", 1, 0, 0, S_HG, 0, 0);
        step("t2_arr", 0, 0, 1, S_HG, 0, 0);
        for (int i = 0; i < 3; i++) step("t2_hg", 0, 0, 0, S_HG, 0, 1);
        for (int i = 0; i < 2; i++) step("t2_hy", 0, 0, 0, S_HY, 0, 1);
        step("t2_rs", 0, 0, 0, S_RS, 0, 1);
        step("t2_sg0", 0, 0, 0, S_SG, 0, 1);
        for (int i = 0; i < 3; i++) step("t2_sg", 0, 0, 0, S_SG, 0, 0);
        for (int i = 0; i < 2; i++) step("t2_sy", 0, 0, 0, S_SY, 0, 0);
        step("t2_rh", 0, 0, 0, S_RH, 0, 0);

        for (int i = 0; i < 12; i++)
            step("t3_hg", 0, 1, (i == 0), S_HG,
                 (i == 0) ? 0 : 1, (i == 0) ? 0 : 1);
        step("t3_hy", 0, 1, 0, S_HY, 1, 1);
        step("t3_rst", 1, 0, 0, S_HY, 2, 1);

        for (int k = 0; k < 57; k++)
            step("t4_sat", 0, 1, 1, st4(k), hq4(k), sq4(k));

        step("t5_rst_sy", 1, 1, 1, S_SY, 31, 31);
        for (int i = 0; i < 3; i++) step("t5_after", 0, 0, 0, S_HG, 0, 0);

        @(negedge traffic_clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
